// File: rtl/relu_maxpool2x2_pkg.sv
// Shared constants and helpers for the ReLU + 2x2 max-pool stage.
// Samples are IEEE-754 single-precision words.
package relu_maxpool2x2_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int FP_SIGN_BIT = FP_WIDTH - 1;
    localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;

    // After ReLU every word is non-negative, so an unsigned word compare orders values.
    function automatic logic [FP_WIDTH-1:0] fp_max(input logic [FP_WIDTH-1:0] a,
                                                   input logic [FP_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool2x2_relu_fp.sv
// Combinational ReLU on a single-precision word.
// Any word with the sign bit set, including -0.0, becomes +0.0.
import relu_maxpool2x2_pkg::*;

module relu_fp (
    input  logic [FP_WIDTH-1:0] sample,
    output logic [FP_WIDTH-1:0] result
);

    // Sign test and zero substitution
    always_comb begin
        result = sample;
        if (sample[FP_SIGN_BIT]) begin
            result = FP_ZERO;
        end else begin
            result = sample;
        end
    end

endmodule

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling over a raster-order
// WIDTH x WIDTH feature map, one output per completed window.
import relu_maxpool2x2_pkg::*;

module relu_maxpool2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int HW    = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam int HALF  = WIDTH / 2;

    generate
        if ((WIDTH % 2) != 0) begin : g_odd_width
            $error("relu_maxpool2x2: WIDTH must be even");
        end
        if (DATA_WIDTH != FP_WIDTH) begin : g_bad_data_width
            $error("relu_maxpool2x2: DATA_WIDTH must equal the single-precision width");
        end
    endgenerate

    logic [CW-1:0]         col_r;
    logic [CW-1:0]         row_r;
    logic [FP_WIDTH-1:0]   pair_r;
    logic [FP_WIDTH-1:0]   linebuf_r [HALF];

    logic [FP_WIDTH-1:0]   relu_s;
    logic [FP_WIDTH-1:0]   pair_max_s;
    logic [FP_WIDTH-1:0]   win_max_s;
    logic [HW-1:0]         half_idx_s;
    logic                  last_col_s;
    logic                  last_row_s;
    logic                  lb_write_s;

    relu_fp u_relu_fp (
        .sample (data_in),
        .result (relu_s)
    );

    // Window position decode and the running maxima for the current pixel
    always_comb begin
        half_idx_s = HW'(col_r >> 1);
        last_col_s = (col_r == CW'(WIDTH - 1));
        last_row_s = (row_r == CW'(WIDTH - 1));
        lb_write_s = valid_in & ~row_r[0] & col_r[0];
        pair_max_s = fp_max(pair_r, relu_s);
        win_max_s  = fp_max(pair_max_s, linebuf_r[half_idx_s]);
    end

    // Counters, pair register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_r      <= {CW{1'b0}};
            row_r      <= {CW{1'b0}};
            pair_r     <= FP_ZERO;
            data_out   <= FP_ZERO;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                col_r <= last_col_s ? {CW{1'b0}} : col_r + CW'(1);
                if (last_col_s) begin
                    row_r <= last_row_s ? {CW{1'b0}} : row_r + CW'(1);
                end
                case ({row_r[0], col_r[0]})
                    2'b00, 2'b10: begin
                        pair_r <= relu_s;
                    end
                    2'b11: begin
                        data_out   <= win_max_s;
                        valid_out  <= 1'b1;
                        frame_done <= last_col_s & last_row_s;
                    end
                    default: begin
                        pair_r <= pair_r;
                    end
                endcase
            end
        end
    end

    // Line buffer: top-row pair maxima, always written before the odd row reads them
    always_ff @(posedge clk) begin
        if (rst && lb_write_s) begin
            linebuf_r[half_idx_s] <= pair_max_s;
        end
    end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Self-checking bench for relu_maxpool2x2 at WIDTH=4: directed frames plus
// random frames, all checked against a frame-array reference model.
module tb_relu_maxpool2x2;

    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    localparam logic [31:0] RAMP [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    localparam logic [31:0] EXP4 [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

    // reference model state: the frame image and the next pixel position
    logic [31:0] img [W][W];
    int          mrow = 0;
    int          mcol = 0;
    logic [31:0] last_q = 32'h0;
    logic [31:0] got [$];

    relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] relu(input logic [31:0] v);
        return v[31] ? 32'h0 : v;
    endfunction

    function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: drive a pixel (or an idle cycle) and check the outputs one cycle later
    task automatic step(input logic v, input logic [31:0] d);
        logic        ev;
        logic        ed;
        logic [31:0] edata;
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        ev = 1'b0;
        ed = 1'b0;
        edata = last_q;
        if (v) begin
            img[mrow][mcol] = d;
            if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
                ev = 1'b1;
                ed = (mrow == W - 1) && (mcol == W - 1);
                edata = umax(umax(relu(img[mrow-1][mcol-1]), relu(img[mrow-1][mcol])),
                             umax(relu(img[mrow][mcol-1]), relu(img[mrow][mcol])));
            end
            mcol = mcol + 1;
            if (mcol == W) begin
                mcol = 0;
                mrow = (mrow + 1) % W;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_out", {31'h0, valid_out}, {31'h0, ev});
        chk("frame_done", {31'h0, frame_done}, {31'h0, ed});
        chk("data_out", data_out, edata);
        last_q = edata;
        if (valid_out) got.push_back(data_out);
        if (frame_done) done_cnt++;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'($urandom_range(0, 1));
        data_in  = $urandom;
        @(posedge clk);
        #1;
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        mrow = 0;
        mcol = 0;
        last_q = 32'h0;
        rst = 1'b1;
    endtask

    task automatic run_ramp(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, RAMP[i]);
            if (gaps && i != 15) begin
                step(1'b0, $urandom);
                step(1'b0, $urandom);
            end
        end
    endtask

    task automatic check_ramp_out(input string tag, input int frames);
        chk({tag, "_count"}, 32'(got.size()), 32'(4 * frames));
        for (int i = 0; i < got.size() && i < 4 * frames; i++) begin
            chk({tag, "_value"}, got[i], EXP4[i % 4]);
        end
        got.delete();
    endtask

    initial begin
        rst = 1'b0;
        valid_in = 1'b0;
        data_in = 32'h0;
        reset_cycle();
        reset_cycle();
        got.delete();

        // ramp frame, continuous valid
        done_cnt = 0;
        run_ramp(1'b0);
        check_ramp_out("ramp", 1);
        chk("ramp_done_cnt", 32'(done_cnt), 32'd1);

        // all -1.0
        for (int i = 0; i < 16; i++) step(1'b1, 32'hBF800000);
        chk("neg_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size(); i++) chk("neg_value", got[i], 32'h0);
        got.delete();

        // mixed-sign window and an all -0.0 window
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            case (i)
                0:       d = 32'h80000000;
                1:       d = 32'hC0000000;
                4:       d = 32'hC0400000;
                5:       d = 32'h3F000000;
                2, 3, 6, 7: d = 32'h80000000;
                default: d = d;
            endcase
            step(1'b1, d);
        end
        chk("win_half", got[0], 32'h3F000000);
        chk("win_negzero", got[1], 32'h0);
        got.delete();

        // ramp frame with valid gaps
        run_ramp(1'b1);
        check_ramp_out("gaps", 1);

        // abort after 6 pixels, then a full frame
        for (int i = 0; i < 6; i++) step(1'b1, $urandom);
        reset_cycle();
        got.delete();
        run_ramp(1'b0);
        check_ramp_out("abort", 1);

        // two frames back-to-back
        done_cnt = 0;
        run_ramp(1'b0);
        run_ramp(1'b0);
        check_ramp_out("b2b", 2);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd2);

        // random frames with random gaps
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b1, $urandom);
                if ($urandom_range(0, 3) == 0) step(1'b0, $urandom);
            end
        end
        got.delete();
        for (int i = 0; i < 4; i++) step(1'b0, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
